// File: rtl/mnist_frame_loader.sv
// Byte-serial frame loader for the MNIST CNN: buffers one image, holds the CNN
// in reset while loading, streams the frame, then collects the class decision.
module mnist_frame_loader #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PIX_BITS   = 8,
    parameter int ADDR_BITS  = 10,
    parameter int ARM_CYCLES = 2,
    parameter int TIMEOUT    = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid_i,
    input  logic [PIX_BITS-1:0] wr_data_i,
    output logic                wr_ready_o,
    output logic                cnn_rst_o,
    output logic [PIX_BITS-1:0] pixel_o,
    input  logic                cnn_done_i,
    input  logic [3:0]          cnn_decision_i,
    output logic                result_valid_o,
    output logic [3:0]          result_o,
    output logic                timeout_o,
    output logic                busy_o
);

    localparam int N       = IMG_W * IMG_H;
    localparam int WC_BITS = $clog2(TIMEOUT + 1);
    localparam int AC_BITS = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);
    localparam logic [WC_BITS-1:0]   WAIT_LAST = WC_BITS'(TIMEOUT - 1);
    localparam logic [AC_BITS-1:0]   ARM_LAST  = AC_BITS'(ARM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_ARM    = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic [AC_BITS-1:0]    arm_cnt_q, arm_cnt_d;
    logic [WC_BITS-1:0]    wait_cnt_q, wait_cnt_d;
    logic                  last_q, last_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  cnn_rst_q, cnn_rst_d;
    logic [PIX_BITS-1:0]   pixel_q, pixel_d;
    logic                  result_valid_q, result_valid_d;
    logic [3:0]            result_q, result_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_s;

    logic [PIX_BITS-1:0]   mem [N];

    assign wr_en_s = (state_q == S_LOAD) && wr_valid_i && wr_ready_q;

    // Frame buffer write port; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_q] <= wr_data_i;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        arm_cnt_d  = arm_cnt_q;
        wait_cnt_d = wait_cnt_q;
        last_d     = last_q;
        pixel_d    = '0;
        result_d   = result_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_LOAD: begin
                if (wr_en_s) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        state_d   = S_ARM;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_BITS'(1);
                    end
                end else begin
                    wr_addr_d = wr_addr_q;
                end
            end
            S_ARM: begin
                // The last arm cycle issues the read of mem[0] so it lands with cnn_rst_o low.
                if (arm_cnt_q == ARM_LAST) begin
                    arm_cnt_d = '0;
                    pixel_d   = mem[rd_addr_q];
                    rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                    state_d   = S_STREAM;
                end else begin
                    arm_cnt_d = arm_cnt_q + AC_BITS'(1);
                end
            end
            S_STREAM: begin
                if (last_q) begin
                    last_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    pixel_d = mem[rd_addr_q];
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_addr_d = '0;
                        last_d    = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                    end
                end
            end
            S_WAIT: begin
                // Done is tested first so it wins over a coincident timeout.
                if (cnn_done_i) begin
                    result_d   = cnn_decision_i;
                    wait_cnt_d = '0;
                    state_d    = S_REPORT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_LOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_BITS'(1);
                end
            end
            S_REPORT: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        wr_ready_d     = (state_d == S_LOAD);
        cnn_rst_d      = (state_d == S_LOAD) || (state_d == S_ARM);
        result_valid_d = (state_d == S_REPORT);
        busy_d         = (state_d != S_LOAD);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_LOAD;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            arm_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            last_q         <= 1'b0;
            wr_ready_q     <= 1'b0;
            cnn_rst_q      <= 1'b1;
            pixel_q        <= '0;
            result_valid_q <= 1'b0;
            result_q       <= 4'd0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            arm_cnt_q      <= arm_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            last_q         <= last_d;
            wr_ready_q     <= wr_ready_d;
            cnn_rst_q      <= cnn_rst_d;
            pixel_q        <= pixel_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign wr_ready_o     = wr_ready_q;
    assign cnn_rst_o      = cnn_rst_q;
    assign pixel_o        = pixel_q;
    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = busy_q;

endmodule
